prog_seq_detector: RTL and testbench

Programmable multi-pattern serial sequence detector for single-bit input streams. It replaces fixed hard-coded detector FSMs with NPAT runtime-loadable patterns of up to MAXLEN bits each. Each pattern has its own length and overlap/non-overlap mode. Outputs are a registered per-pattern hit pulse, an encoded match code y, and saturating per-pattern hit counters.

---
 rtl/prog_seq_detector.sv | 118 +++++++++++
 tb/tb_prog_seq_detector.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_seq_detector.sv
// Programmable multi-pattern serial sequence detector: NPAT runtime-loadable
// patterns matched against one shared bit history, with hit pulses and counters.
module prog_seq_detector #(
  parameter  int NPAT   = 2,
  parameter  int MAXLEN = 8,
  parameter  int CNTW   = 8,
  localparam int IW     = (NPAT > 1) ? $clog2(NPAT) : 1,
  localparam int LW     = $clog2(MAXLEN + 1),
  localparam int YW     = $clog2(NPAT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x_valid,
  input  logic                 x,
  input  logic                 cfg_we,
  input  logic [IW-1:0]        cfg_idx,
  input  logic [MAXLEN-1:0]    cfg_pattern,
  input  logic [LW-1:0]        cfg_len,
  input  logic                 cfg_overlap,
  input  logic                 clr_cnt,
  output logic [NPAT-1:0]      hit,
  output logic [YW-1:0]        y,
  output logic [NPAT*CNTW-1:0] hit_count
);

  logic [MAXLEN-1:0] hist_q, hist_d;
  logic [MAXLEN-1:0] pat_q  [NPAT];
  logic [MAXLEN-1:0] pat_d  [NPAT];
  logic [LW-1:0]     len_q  [NPAT];
  logic [LW-1:0]     len_d  [NPAT];
  logic [LW-1:0]     fill_q [NPAT];
  logic [LW-1:0]     fill_d [NPAT];
  logic [CNTW-1:0]   cnt_q  [NPAT];
  logic [CNTW-1:0]   cnt_d  [NPAT];
  logic [NPAT-1:0]   ovl_q, ovl_d;
  logic [NPAT-1:0]   hit_q, hit_d;
  logic [YW-1:0]     y_q, y_d;

  // Only the low len bits of a pattern take part in the compare.
  function automatic logic [MAXLEN-1:0] len_mask(input logic [LW-1:0] len);
    logic [MAXLEN-1:0] m;
    for (int b = 0; b < MAXLEN; b++) m[b] = (b < int'(len));
    return m;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    hist_d = x_valid ? {hist_q[MAXLEN-2:0], x} : hist_q;
    ovl_d  = ovl_q;
    hit_d  = '0;
    y_d    = '0;
    for (int i = 0; i < NPAT; i++) begin
      pat_d[i]  = pat_q[i];
      len_d[i]  = len_q[i];
      fill_d[i] = fill_q[i];
      cnt_d[i]  = cnt_q[i];
      if (cfg_we && (cfg_idx == IW'(i))) begin
        pat_d[i]  = cfg_pattern;
        len_d[i]  = cfg_len;
        ovl_d[i]  = cfg_overlap;
        fill_d[i] = '0;
        cnt_d[i]  = '0;
      end else if ((len_q[i] == '0) || (len_q[i] > LW'(MAXLEN))) begin
        fill_d[i] = '0;
      end else if (x_valid) begin
        // fill_q counts earlier fresh bits; the bit arriving now makes fill_q+1.
        hit_d[i] = ((LW+1)'(fill_q[i]) + (LW+1)'(1) >= (LW+1)'(len_q[i])) &&
                   (((hist_d ^ pat_q[i]) & len_mask(len_q[i])) == '0);
        if (hit_d[i] && !ovl_q[i])          fill_d[i] = '0;
        else if (fill_q[i] != LW'(MAXLEN))  fill_d[i] = fill_q[i] + LW'(1);
        if (hit_d[i] && (cnt_q[i] != '1))   cnt_d[i]  = cnt_q[i] + CNTW'(1);
      end
      if (clr_cnt) cnt_d[i] = '0;
    end
    for (int i = NPAT - 1; i >= 0; i--) begin
      if (hit_d[i]) y_d = YW'(i + 1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      ovl_q  <= '0;
      hit_q  <= '0;
      y_q    <= '0;
      // NOTE: the slot config arrays are small flop banks, not RAM, and must
      // come out of reset disabled, so they are reset like any other state.
      for (int i = 0; i < NPAT; i++) begin
        pat_q[i]  <= '0;
        len_q[i]  <= '0;
        fill_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      hist_q <= hist_d;
      ovl_q  <= ovl_d;
      hit_q  <= hit_d;
      y_q    <= y_d;
      for (int i = 0; i < NPAT; i++) begin
        pat_q[i]  <= pat_d[i];
        len_q[i]  <= len_d[i];
        fill_q[i] <= fill_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign hit = hit_q;
  assign y   = y_q;

  for (genvar g = 0; g < NPAT; g++) begin : g_cnt
    assign hit_count[g*CNTW +: CNTW] = cnt_q[g];
  end

endmodule

// File: tb/tb_prog_seq_detector.sv
// Self-checking bench for prog_seq_detector: directed scenarios plus a random
// run, all compared against a bit-queue reference model.
module tb_prog_seq_detector;
  localparam int NPAT   = 2;
  localparam int MAXLEN = 8;
  localparam int CNTW   = 8;
  localparam int IW     = (NPAT > 1) ? $clog2(NPAT) : 1;
  localparam int LW     = $clog2(MAXLEN + 1);
  localparam int YW     = $clog2(NPAT + 1);
  localparam int CMAX   = (1 << CNTW) - 1;

  logic                 clk = 1'b0;
  logic                 rst, x_valid, x, cfg_we, cfg_overlap, clr_cnt;
  logic [IW-1:0]        cfg_idx;
  logic [MAXLEN-1:0]    cfg_pattern;
  logic [LW-1:0]        cfg_len;
  logic [NPAT-1:0]      hit;
  logic [YW-1:0]        y;
  logic [NPAT*CNTW-1:0] hit_count;

  int checks = 0;
  int errors = 0;

  prog_seq_detector #(.NPAT(NPAT), .MAXLEN(MAXLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_cnt(clr_cnt), .hit(hit), .y(y),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // Reference model: the valid-bit stream as a queue and, per slot, how many
  // fresh bits arrived since its last config write or consuming match.
  bit                hq[$];
  int                fresh [NPAT];
  logic [MAXLEN-1:0] mpat  [NPAT];
  int                mlen  [NPAT];
  bit                movl  [NPAT];
  int                mcnt  [NPAT];
  logic [NPAT-1:0]   m_hit;
  logic [YW-1:0]     m_y;

  function automatic logic [NPAT*CNTW-1:0] m_flat();
    logic [NPAT*CNTW-1:0] f;
    for (int i = 0; i < NPAT; i++) f[i*CNTW +: CNTW] = CNTW'(mcnt[i]);
    return f;
  endfunction

  task automatic model_step();
    logic [NPAT-1:0] nh;
    bit ok;
    nh = '0;
    if (rst) begin
      hq.delete();
      for (int i = 0; i < NPAT; i++) begin
        fresh[i] = 0; mpat[i] = '0; mlen[i] = 0; movl[i] = 0; mcnt[i] = 0;
      end
    end else begin
      if (x_valid) begin
        hq.push_back(x);
        if (hq.size() > MAXLEN) void'(hq.pop_front());
      end
      for (int i = 0; i < NPAT; i++) begin
        if (cfg_we && int'(cfg_idx) == i) begin
          mpat[i] = cfg_pattern; mlen[i] = int'(cfg_len); movl[i] = cfg_overlap;
          fresh[i] = 0; mcnt[i] = 0;
        end else if (x_valid && mlen[i] >= 1 && mlen[i] <= MAXLEN) begin
          fresh[i]++;
          if (fresh[i] >= mlen[i]) begin
            ok = 1;
            // Oldest of the last len received bits must equal pattern bit len-1.
            for (int k = 0; k < mlen[i]; k++)
              if (hq[hq.size() - mlen[i] + k] != mpat[i][mlen[i] - 1 - k]) ok = 0;
            if (ok) begin
              nh[i] = 1'b1;
              if (!movl[i]) fresh[i] = 0;
              if (mcnt[i] < CMAX) mcnt[i]++;
            end
          end
        end
        if (clr_cnt) mcnt[i] = 0;
      end
    end
    m_hit = nh;
    m_y   = '0;
    for (int i = NPAT - 1; i >= 0; i--) if (nh[i]) m_y = YW'(i + 1);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; x_valid = 0; x = 0; cfg_we = 0; cfg_idx = '0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; clr_cnt = 0;
  endtask

  task automatic cfg(input int idx, input logic [MAXLEN-1:0] pat, input int len,
                     input bit ovl, input bit xv, input bit xb);
    cfg_we = 1; cfg_idx = IW'(idx); cfg_pattern = pat; cfg_len = LW'(len);
    cfg_overlap = ovl; x_valid = xv; x = xb;
    tick();
    cfg_we = 0; x_valid = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (hit !== '0 || y !== '0 || hit_count !== '0) begin
      errors++;
      $display("FAIL reset: hit=%b y=%0d cnt=%h, want all zero", hit, y, hit_count);
    end
    x_valid = 1; x = 1; tick(); x_valid = 0;
    checks++;
    if (hit !== '0 || y !== '0) begin
      errors++;
      $display("FAIL reset_disabled: hit=%b y=%0d, want 0 0", hit, y);
    end
  endtask

  task automatic test_basic();
    logic [4:0] s;
    s = 5'b10001;
    do_reset();
    cfg(0, 8'b10001, 5, 1, 0, 0);
    for (int b = 4; b >= 0; b--) begin
      x_valid = 1; x = s[b]; tick();
      checks++;
      if ({hit, y, hit_count} !== {m_hit, m_y, m_flat()}) begin
        errors++;
        $display("FAIL basic bit%0d: got hit=%b y=%0d cnt=%h want hit=%b y=%0d cnt=%h",
                 4 - b, hit, y, hit_count, m_hit, m_y, m_flat());
      end
    end
    x_valid = 0;
    checks++;
    if (hit !== 2'b01 || y !== 2'd1 || hit_count[7:0] !== 8'd1) begin
      errors++;
      $display("FAIL basic_final: hit=%b y=%0d cnt0=%0d, want 01 1 1", hit, y, hit_count[7:0]);
    end
    tick();
    checks++;
    if (hit !== '0) begin
      errors++;
      $display("FAIL basic_pulse: hit=%b, want 00", hit);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] s;
    s = 7'b1010101;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      cfg(1, 8'b10101, 5, (pass == 0), 0, 0);
      for (int b = 6; b >= 0; b--) begin
        x_valid = 1; x = s[b]; tick();
        checks++;
        if ({hit, y, hit_count} !== {m_hit, m_y, m_flat()}) begin
          errors++;
          $display("FAIL overlap p%0d bit%0d: got hit=%b y=%0d cnt=%h want hit=%b y=%0d cnt=%h",
                   pass, 6 - b, hit, y, hit_count, m_hit, m_y, m_flat());
        end
      end
      x_valid = 0;
      checks++;
      if (hit_count[15:8] !== ((pass == 0) ? 8'd2 : 8'd1)) begin
        errors++;
        $display("FAIL overlap_count p%0d: cnt1=%0d, want %0d", pass, hit_count[15:8],
                 (pass == 0) ? 2 : 1);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] s;
    s = 5'b10101;
    do_reset();
    cfg(0, 8'b101, 3, 1, 0, 0);
    cfg(1, 8'b10101, 5, 1, 0, 0);
    for (int b = 4; b >= 0; b--) begin
      x_valid = 1; x = s[b]; tick();
      checks++;
      if ({hit, y, hit_count} !== {m_hit, m_y, m_flat()}) begin
        errors++;
        $display("FAIL simul bit%0d: got hit=%b y=%0d want hit=%b y=%0d",
                 4 - b, hit, y, m_hit, m_y);
      end
      if (b == 2) begin
        checks++;
        if (hit !== 2'b01) begin
          errors++;
          $display("FAIL simul_bit3: hit=%b, want 01", hit);
        end
      end
    end
    x_valid = 0;
    checks++;
    if (hit !== 2'b11 || y !== 2'd1) begin
      errors++;
      $display("FAIL simul_bit5: hit=%b y=%0d, want 11 1", hit, y);
    end
  endtask

  task automatic test_gaps();
    logic [4:0] s;
    s = 5'b10001;
    do_reset();
    cfg(0, 8'b10001, 5, 0, 0, 0);
    for (int b = 4; b >= 0; b--) begin
      x_valid = 1; x = s[b]; tick();
      for (int g = 0; g <= 3; g++) begin
        checks++;
        if ({hit, y, hit_count} !== {m_hit, m_y, m_flat()}) begin
          errors++;
          $display("FAIL gaps bit%0d gap%0d: got hit=%b y=%0d want hit=%b y=%0d",
                   4 - b, g, hit, y, m_hit, m_y);
        end
        if (g < 3) begin
          x_valid = 0; x = $urandom_range(0, 1); tick();
        end
      end
    end
    checks++;
    if (hit_count[7:0] !== 8'd1) begin
      errors++;
      $display("FAIL gaps_count: cnt0=%0d, want 1", hit_count[7:0]);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    cfg(0, 8'b1, 1, 1, 0, 0);
    for (int n = 0; n < 300; n++) begin
      x_valid = 1; x = 1; tick();
      checks++;
      if ({hit, y, hit_count} !== {m_hit, m_y, m_flat()}) begin
        errors++;
        $display("FAIL sat n%0d: got hit=%b cnt=%h want hit=%b cnt=%h",
                 n, hit, hit_count, m_hit, m_flat());
      end
    end
    checks++;
    if (hit_count[7:0] !== 8'd255) begin
      errors++;
      $display("FAIL sat_hold: cnt0=%0d, want 255", hit_count[7:0]);
    end
    clr_cnt = 1; tick(); clr_cnt = 0; x_valid = 0;
    checks++;
    if (hit[0] !== 1'b1 || hit_count[7:0] !== 8'd0) begin
      errors++;
      $display("FAIL sat_clear: hit0=%b cnt0=%0d, want 1 0", hit[0], hit_count[7:0]);
    end
  endtask

  task automatic test_midreset();
    logic [3:0] s;
    s = 4'b1000;
    do_reset();
    cfg(0, 8'b10001, 5, 1, 0, 0);
    cfg(1, 8'b1, 1, 1, 0, 0);
    for (int b = 3; b >= 0; b--) begin x_valid = 1; x = s[b]; tick(); end
    do_reset();
    x_valid = 1; x = 1; tick(); x_valid = 0;
    checks++;
    if (hit !== '0 || y !== '0 || hit_count !== '0) begin
      errors++;
      $display("FAIL midreset: hit=%b y=%0d cnt=%h, want all zero", hit, y, hit_count);
    end
    // Reprogram mid-pattern: the completing bit arrives with the write itself.
    cfg(0, 8'b10001, 5, 1, 0, 0);
    for (int b = 3; b >= 0; b--) begin x_valid = 1; x = s[b]; tick(); end
    cfg(0, 8'b10001, 5, 1, 1, 1);
    checks++;
    if (hit !== '0) begin
      errors++;
      $display("FAIL reconfig_write: hit=%b, want 00", hit);
    end
    for (int n = 0; n < 5; n++) begin
      x_valid = 1; x = (n == 0 || n == 4); tick();
      checks++;
      if (hit[0] !== (n == 4) || hit !== m_hit) begin
        errors++;
        $display("FAIL reconfig fresh%0d: hit=%b model=%b", n + 1, hit, m_hit);
      end
    end
    x_valid = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      idle();
      rst     = ($urandom_range(0, 999) == 0);
      x_valid = ($urandom_range(0, 3) != 0);
      x       = $urandom_range(0, 1);
      clr_cnt = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 31) == 0) begin
        cfg_we      = 1;
        cfg_idx     = IW'($urandom_range(0, NPAT - 1));
        cfg_pattern = MAXLEN'($urandom);
        cfg_len     = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, (1 << LW) - 1))
                                                  : LW'($urandom_range(1, 4));
        cfg_overlap = $urandom_range(0, 1);
      end
      tick();
      checks++;
      if ({hit, y, hit_count} !== {m_hit, m_y, m_flat()}) begin
        errors++;
        $display("FAIL random n%0d: got hit=%b y=%0d cnt=%h want hit=%b y=%0d cnt=%h",
                 n, hit, y, hit_count, m_hit, m_y, m_flat());
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_overlap();
    test_simultaneous();
    test_gaps();
    test_saturation();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
